// File: rtl/subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_pkg
// Description : Shared widths, scan-select bit positions, LED bit indices,
//               load-target encoding and the active-low 7-segment font
//               (bit 6 = a ... bit 0 = g) for the subtractor board block.
// Revision    : 1.0  initial release
// ============================================================================
package subtractor_pkg;

    localparam int OP_W  = 16;  // operand width
    localparam int CNT_W = 27;  // scan counter width
    localparam int NDIG  = 8;   // number of display digits
    localparam int SCAN_W = 3;  // digit-select width, log2(NDIG)

    // Lowest counter bit used as the digit select.
    localparam int SCAN_LSB_SLOW = 17;  // ~1.3 ms per digit at 100 MHz
    localparam int SCAN_LSB_FAST = 0;   // one digit per clock

    // LED bit positions.
    localparam int LED_BORROW = 0;
    localparam int LED_ZERO   = 1;
    localparam int LED_OVF    = 2;
    localparam int LED_SELB   = 3;

    // Which operand the next load writes.
    typedef enum logic {
        TGT_A = 1'b0,
        TGT_B = 1'b1
    } load_tgt_e;

    // Active-low hex font.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

endpackage : subtractor_pkg
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational 4-bit hex to active-low 7-segment decoder.
// Ports       : nibble  in  4  hex digit value
//               seg     out 7  segments, active-low, bit 6 = a ... bit 0 = g
// Revision    : 1.0  initial release
// ============================================================================
module hex_to_7seg
    import subtractor_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule : hex_to_7seg
`default_nettype wire

// File: rtl/subtractor.sv
`default_nettype none
// ============================================================================
// Module      : subtractor
// Description : Board-level 16-bit operand subtractor. Center alternately
//               loads SW into A and B; the display shows |A-B| on digits
//               3..0 and A on digits 7..4; LEDs show the arithmetic flags.
// Ports       : CLK100MHZ   in   1   100 MHz clock
//               CPU_RESETN  in   1   synchronous active-low reset
//               SW          in  16   operand value
//               Center      in   1   asynchronous load button, active-high
//               AN          out  8   digit anodes, active-low (registered)
//               a_to_g      out  7   segments, active-low (registered)
//               LED         out  4   {selB, ovf, zero, borrow}
//               A, B        out 16   operand registers
//               C           out 27   free-running scan counter
// Config      : SIM_FAST_SCAN_EN - when defined the digit select is C[2:0]
//               instead of C[19:17], so all digits cycle every 8 clocks.
// Revision    : 1.0  initial release
// ============================================================================
module subtractor
    import subtractor_pkg::*;
(
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [OP_W-1:0]   SW,
    input  logic              Center,
    output logic [NDIG-1:0]   AN,
    output logic [6:0]        a_to_g,
    output logic [3:0]        LED,
    output logic [OP_W-1:0]   A,
    output logic [OP_W-1:0]   B,
    output logic [CNT_W-1:0]  C
);

`ifdef SIM_FAST_SCAN_EN
    localparam int SCAN_LSB = SCAN_LSB_FAST;
`else
    localparam int SCAN_LSB = SCAN_LSB_SLOW;
`endif

    // Button path
    logic sync1;
    logic sync2;
    logic sync2_d;
    logic primed;   // first post-reset sample has been taken
    logic armed;    // a genuine low level has been seen since reset
    logic load;

    // Load target
    load_tgt_e tgt;
    load_tgt_e tgt_next;

    // Arithmetic
    logic [OP_W-1:0] diff;
    logic [OP_W-1:0] mag;
    logic            borrow;
    logic            zero;
    logic            ovf;

    // Display
    logic [SCAN_W-1:0] dsel;
    logic [OP_W-1:0]   disp_src;
    logic [3:0]        nibble;
    logic [6:0]        seg;

    // ------------------------------------------------------------------
    // Synchronizer, edge detector and operand registers.
    // The edge detector only fires once a real low sample has been taken
    // after reset, so a button held through reset cannot masquerade as a
    // fresh press when the cleared synchronizer refills with ones.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            primed  <= 1'b0;
            armed   <= 1'b0;
            load    <= 1'b0;
            tgt     <= TGT_A;
            A       <= '0;
            B       <= '0;
        end else begin
            sync1   <= Center;
            sync2   <= sync1;
            sync2_d <= sync2;
            primed  <= 1'b1;
            if (primed && !sync1) begin
                armed <= 1'b1;
            end
            load    <= sync2 & ~sync2_d & armed;
            tgt     <= tgt_next;
            if (load && (tgt == TGT_A)) begin
                A <= SW;
            end
            if (load && (tgt == TGT_B)) begin
                B <= SW;
            end
        end
    end

    always_comb begin
        tgt_next = tgt;
        if (load) begin
            tgt_next = (tgt == TGT_A) ? TGT_B : TGT_A;
        end
    end

    // ------------------------------------------------------------------
    // Flags and magnitude
    // ------------------------------------------------------------------
    always_comb begin
        diff   = A - B;
        borrow = (A < B);
        zero   = (A == B);
        mag    = borrow ? (B - A) : diff;
        // Operands of differing sign whose wrapped result flips A's sign.
        ovf    = (A[OP_W-1] != B[OP_W-1]) && (diff[OP_W-1] != A[OP_W-1]);
    end

    always_comb begin
        LED             = '0;
        LED[LED_BORROW] = borrow;
        LED[LED_ZERO]   = zero;
        LED[LED_OVF]    = ovf;
        LED[LED_SELB]   = (tgt == TGT_B);
    end

    // ------------------------------------------------------------------
    // Digit mux: digits 0..3 carry mag, digits 4..7 carry A.
    // ------------------------------------------------------------------
    assign dsel = C[SCAN_LSB +: SCAN_W];

    always_comb begin
        disp_src = dsel[2] ? A : mag;
        nibble   = 4'h0;
        case (dsel[1:0])
            2'd0: nibble = disp_src[3:0];
            2'd1: nibble = disp_src[7:4];
            2'd2: nibble = disp_src[11:8];
            2'd3: nibble = disp_src[15:12];
            default: nibble = 4'h0;
        endcase
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (seg)
    );

    // ------------------------------------------------------------------
    // Scan counter and registered display outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            C      <= '0;
            AN     <= {{(NDIG-1){1'b1}}, 1'b0};
            a_to_g <= SEG_0;
        end else begin
            C      <= C + CNT_W'(1);
            AN     <= ~({{(NDIG-1){1'b0}}, 1'b1} << dsel);
            a_to_g <= seg;
        end
    end

endmodule : subtractor
`default_nettype wire

// File: tb/tb_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor
// Description : Self-checking bench for subtractor. A behavioural model of
//               the board block is compared against every output each cycle,
//               alongside a table of hand-computed operand/flag vectors and
//               directed button/reset corner cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_subtractor;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sw;
    logic        center;
    logic [7:0]  an;
    logic [6:0]  a_to_g;
    logic [3:0]  led;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [26:0] c_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subtractor dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rstn),
        .SW         (sw),
        .Center     (center),
        .AN         (an),
        .a_to_g     (a_to_g),
        .LED        (led),
        .A          (a_out),
        .B          (b_out),
        .C          (c_out)
    );

    localparam logic [6:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // ---------------- reference arithmetic ----------------
    function automatic logic [15:0] ref_mag(input logic [15:0] a, input logic [15:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        return 16'((ia >= ib) ? (ia - ib) : (ib - ia));
    endfunction

    function automatic logic [3:0] ref_led(input logic [15:0] a, input logic [15:0] b,
                                           input logic sel);
        int sa;
        int sb;
        int d;
        logic ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        d  = sa - sb;
        ov = (d > 32767) || (d < -32768);
        return {sel, ov, (a == b), (a < b)};
    endfunction

    function automatic int dsel_of(input logic [26:0] c);
`ifdef SIM_FAST_SCAN_EN
        return int'(c % 27'd8);
`else
        return int'((c >> 17) % 27'd8);
`endif
    endfunction

    function automatic logic [3:0] disp_nib(input logic [15:0] a, input logic [15:0] b,
                                            input int d);
        logic [15:0] src;
        src = (d < 4) ? ref_mag(a, b) : a;
        return 4'((src >> (4 * (d % 4))) & 16'hF);
    endfunction

    // ---------------- behavioural model ----------------
    // h_val[k] is the Center level sampled k+1 edges ago; h_real marks
    // samples taken after reset (reset wipes the history). A load lands
    // three edges after a genuine low-to-high sample pair.
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_sel;
    logic [26:0] m_c;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic [3:0]  h_val;
    logic [3:0]  h_real;

    always @(posedge clk) begin
        if (!rstn) begin
            m_a    <= 16'h0;
            m_b    <= 16'h0;
            m_sel  <= 1'b0;
            m_c    <= 27'd0;
            m_an   <= 8'hFE;
            m_seg  <= FONT[0];
            h_val  <= 4'b0;
            h_real <= 4'b0;
        end else begin
            if (h_val[2] && !h_val[3] && h_real[3]) begin
                if (!m_sel) m_a <= sw;
                else        m_b <= sw;
                m_sel <= ~m_sel;
            end
            h_val  <= {h_val[2:0], center};
            h_real <= {h_real[2:0], 1'b1};
            m_c    <= m_c + 27'd1;
            m_an   <= ~(8'd1 << dsel_of(m_c));
            m_seg  <= FONT[disp_nib(m_a, m_b, dsel_of(m_c))];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic scoreboard();
        check("sb_A", 32'(a_out), 32'(m_a));
        check("sb_B", 32'(b_out), 32'(m_b));
        check("sb_C", 32'(c_out), 32'(m_c));
        check("sb_LED", 32'(led), 32'(ref_led(m_a, m_b, m_sel)));
        check("sb_AN", 32'(an), 32'(m_an));
        check("sb_seg", 32'(a_to_g), 32'(m_seg));
    endtask

    task automatic tick();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic press(input logic [15:0] v);
        sw = v;
        center = 1'b1;
        repeat (3) tick();
        center = 1'b0;
        repeat (4) tick();
    endtask

    // Observe the display for 16 cycles and check every digit shown.
    task automatic check_digits(input logic [15:0] exp_mag, input logic [15:0] exp_a);
        int d;
        logic [15:0] src;
        repeat (16) begin
            tick();
            d = -1;
            for (int i = 0; i < 8; i++) begin
                if (an == ~(8'd1 << i)) d = i;
            end
            check("digit_an_onehot", 32'(d >= 0), 32'd1);
            if (d >= 0) begin
                src = (d < 4) ? exp_mag : exp_a;
                check("digit_seg", 32'(a_to_g),
                      32'(FONT[4'((src >> (4 * (d % 4))) & 16'hF)]));
            end
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  led;
        logic [15:0] mag;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{a: 16'h0002, b: 16'h00F0, led: 4'b0001, mag: 16'h00EE};
        vecs[1] = '{a: 16'h000F, b: 16'h00F0, led: 4'b0001, mag: 16'h00E1};
        vecs[2] = '{a: 16'h8000, b: 16'h0001, led: 4'b0100, mag: 16'h7FFF};
        vecs[3] = '{a: 16'h1234, b: 16'h1234, led: 4'b0010, mag: 16'h0000};
        vecs[4] = '{a: 16'h0001, b: 16'h8000, led: 4'b0101, mag: 16'h7FFF};
        vecs[5] = '{a: 16'hFFFF, b: 16'h0000, led: 4'b0000, mag: 16'hFFFF};
        vecs[6] = '{a: 16'h7FFF, b: 16'hFFFF, led: 4'b0101, mag: 16'h8000};
        vecs[7] = '{a: 16'h0000, b: 16'hFFFF, led: 4'b0001, mag: 16'hFFFF};

        rstn = 1'b0;
        center = 1'b0;
        sw = 16'h0;

        // Reset state
        repeat (3) tick();
        check("rst_A", 32'(a_out), 32'h0);
        check("rst_B", 32'(b_out), 32'h0);
        check("rst_C", 32'(c_out), 32'h0);
        check("rst_LED", 32'(led), 32'b0010);
        check("rst_AN", 32'(an), 32'hFE);
        check("rst_seg", 32'(a_to_g), 32'b0000001);
        rstn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("count_after_reset", 32'(c_out), 32'(i));
        end

        // Load A, load B, reload A
        press(16'h0002);
        check("loadA_A", 32'(a_out), 32'h0002);
        check("loadA_B", 32'(b_out), 32'h0);
        check("loadA_LED", 32'(led), 32'b1000);
        check_digits(16'h0002, 16'h0002);
        press(16'h00F0);
        check("loadB_B", 32'(b_out), 32'h00F0);
        check("loadB_LED", 32'(led), 32'b0001);
        check_digits(16'h00EE, 16'h0002);
        press(16'h000F);
        check("reloadA_A", 32'(a_out), 32'h000F);
        check("reloadA_B", 32'(b_out), 32'h00F0);
        check("reloadA_LED", 32'(led), 32'b1001);
        check_digits(16'h00E1, 16'h000F);
        press(16'h00F0);  // back to targeting A

        // Table of operand pairs
        for (int i = 0; i < 8; i++) begin
            press(vecs[i].a);
            press(vecs[i].b);
            check("vec_A", 32'(a_out), 32'(vecs[i].a));
            check("vec_B", 32'(b_out), 32'(vecs[i].b));
            check("vec_LED", 32'(led), 32'(vecs[i].led));
            check_digits(vecs[i].mag, vecs[i].a);
        end

        // Held button gives exactly one load
        sw = 16'h5555;
        center = 1'b1;
        repeat (8) tick();
        sw = 16'hAAAA;
        repeat (12) tick();
        center = 1'b0;
        repeat (4) tick();
        check("held_A", 32'(a_out), 32'h5555);
        check("held_B", 32'(b_out), 32'h0000FFFF);
        check("held_sel", 32'(led[3]), 32'd1);

        // Press in progress during reset is discarded
        center = 1'b1;
        sw = 16'h1111;
        tick();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();
        check("held_rst_A", 32'(a_out), 32'h0);
        check("held_rst_sel", 32'(led[3]), 32'd0);
        center = 1'b0;
        repeat (3) tick();
        press(16'h2222);
        check("after_rst_press_A", 32'(a_out), 32'h2222);

        // Reset on the same edge that samples load
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        sw = 16'hABCD;
        center = 1'b1;
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        check("rst_prio_A", 32'(a_out), 32'h0);
        rstn = 1'b1;
        center = 1'b0;
        repeat (4) tick();
        check("rst_prio_A_later", 32'(a_out), 32'h0);
        check("rst_prio_LED", 32'(led), 32'b0010);

        // Randomised stimulus against the model
        for (int i = 0; i < 800; i++) begin
            sw = 16'($urandom);
            if ($urandom_range(0, 5) == 0) center = ~center;
            rstn = ($urandom_range(0, 149) != 0);
            tick();
        end
        rstn = 1'b1;
        center = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_subtractor
`default_nettype wire
